// File: rtl/scr1_ahb_tb_pkg.sv
// Shared constants for the SCR1 AHB testbench memory: bus codes, MMIO map,
// default stall pattern and the per-port data-phase state.
package scr1_ahb_tb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   localparam logic [31:0] MMIO_PRINT    = 32'hF000_0000;
   localparam logic [31:0] MMIO_EXT_IRQ  = 32'hF000_0100;
   localparam logic [31:0] MMIO_SOFT_IRQ = 32'hF000_0200;

   localparam logic [31:0] STALL_DEFAULT = 32'hFFFF_FFFF;

   typedef enum logic {
      PH_IDLE = 1'b0,
      PH_DATA = 1'b1
   } phase_e;

endpackage

// File: rtl/scr1_ahb_tb_port_ctrl.sv
// One AHB-Lite slave port sequencer: accepts address phases, tracks the data
// phase and generates hready from a rotating stall pattern.
module scr1_ahb_tb_port_ctrl
   import scr1_ahb_tb_pkg::*;
#(
   parameter int AW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [31:0]   stall_in,
   input  logic [1:0]    htrans,
   input  logic [AW-1:0] haddr,
   input  logic [2:0]    hsize,
   input  logic          hwrite,
   output logic          hready,
   output logic          data_phase,
   output logic          done,
   output logic [AW-1:0] addr_q,
   output logic [2:0]    size_q,
   output logic          write_q
);

   phase_e      state_q;
   phase_e      state_d;
   logic [31:0] stall_q;
   logic        is_xfer;
   logic        accept;

   // Handshake: an address phase is taken on the edge where htrans is
   // NONSEQ/SEQ and hready=1; its data phase ends on the edge where hready=1,
   // which may simultaneously accept the next address phase.
   assign data_phase = (state_q == PH_DATA);
   assign hready     = rst | ~data_phase | stall_q[0];
   assign done       = data_phase & stall_q[0] & ~rst;
   assign accept     = is_xfer & hready & ~rst;

   always_comb begin
      is_xfer = 1'b0;
      case (htrans)
         HTRANS_NONSEQ, HTRANS_SEQ: is_xfer = 1'b1;
         HTRANS_IDLE, HTRANS_BUSY:  is_xfer = 1'b0;
         default:                   is_xfer = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         PH_IDLE: if (accept) state_d = PH_DATA;
         PH_DATA: if (stall_q[0]) state_d = accept ? PH_DATA : PH_IDLE;
         default: state_d = PH_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= PH_IDLE;
         stall_q <= (stall_in == '0) ? STALL_DEFAULT : stall_in;
         addr_q  <= '0;
         size_q  <= '0;
         write_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (data_phase) stall_q <= {stall_q[0], stall_q[31:1]};
         if (accept) begin
            addr_q  <= haddr;
            size_q  <= hsize;
            write_q <= hwrite;
         end
      end
   end

endmodule

// File: rtl/scr1_ahb_tb_mem.sv
// Dual-port AHB-Lite simulation memory: read-only IMEM, read/write DMEM over
// one shared byte array, plus console/IRQ MMIO on the DMEM side.
module scr1_ahb_tb_mem
   import scr1_ahb_tb_pkg::*;
#(
   parameter int SCR1_MEM_POWER_SIZE = 16,
   parameter int SCR1_AHB_WIDTH      = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   output logic                      ext_irq,
   output logic                      soft_irq,
   input  logic [31:0]               imem_req_ack_stall_in,
   input  logic [31:0]               dmem_req_ack_stall_in,
   input  logic [2:0]                imem_hsize,
   input  logic [1:0]                imem_htrans,
   input  logic [SCR1_AHB_WIDTH-1:0] imem_haddr,
   output logic                      imem_hready,
   output logic [SCR1_AHB_WIDTH-1:0] imem_hrdata,
   output logic                      imem_hresp,
   input  logic [2:0]                dmem_hsize,
   input  logic [1:0]                dmem_htrans,
   input  logic [SCR1_AHB_WIDTH-1:0] dmem_haddr,
   input  logic                      dmem_hwrite,
   input  logic [SCR1_AHB_WIDTH-1:0] dmem_hwdata,
   output logic                      dmem_hready,
   output logic [SCR1_AHB_WIDTH-1:0] dmem_hrdata,
   output logic                      dmem_hresp
);

   localparam int P  = SCR1_MEM_POWER_SIZE;
   localparam int AW = SCR1_AHB_WIDTH;

   logic [7:0] memory [0:(2**P)-1];

   logic          i_done, i_write, i_data_phase;
   logic [AW-1:0] i_addr;
   logic [2:0]    i_size;
   logic          d_done, d_write, d_data_phase;
   logic [AW-1:0] d_addr;
   logic [2:0]    d_size;
   logic [31:0]   i_word, d_word, d_rdata;
   logic [3:0]    d_be;
   logic          d_mmio;
   logic          unused_sigs;

   scr1_ahb_tb_port_ctrl #(.AW(AW)) u_imem_ctrl (
      .clk        (clk),
      .rst        (rst),
      .stall_in   (imem_req_ack_stall_in),
      .htrans     (imem_htrans),
      .haddr      (imem_haddr),
      .hsize      (imem_hsize),
      .hwrite     (1'b0),
      .hready     (imem_hready),
      .data_phase (i_data_phase),
      .done       (i_done),
      .addr_q     (i_addr),
      .size_q     (i_size),
      .write_q    (i_write)
   );

   scr1_ahb_tb_port_ctrl #(.AW(AW)) u_dmem_ctrl (
      .clk        (clk),
      .rst        (rst),
      .stall_in   (dmem_req_ack_stall_in),
      .htrans     (dmem_htrans),
      .haddr      (dmem_haddr),
      .hsize      (dmem_hsize),
      .hwrite     (dmem_hwrite),
      .hready     (dmem_hready),
      .data_phase (d_data_phase),
      .done       (d_done),
      .addr_q     (d_addr),
      .size_q     (d_size),
      .write_q    (d_write)
   );

   assign unused_sigs = ^{i_addr[AW-1:P], i_addr[1:0], i_size, i_write,
                          i_data_phase, d_data_phase};

   // Reads sample the array before this edge's DMEM commit, so an IMEM read
   // completing alongside a DMEM write to the same word sees the old data.
   assign i_word = {memory[{i_addr[P-1:2], 2'd3}], memory[{i_addr[P-1:2], 2'd2}],
                    memory[{i_addr[P-1:2], 2'd1}], memory[{i_addr[P-1:2], 2'd0}]};
   assign d_word = {memory[{d_addr[P-1:2], 2'd3}], memory[{d_addr[P-1:2], 2'd2}],
                    memory[{d_addr[P-1:2], 2'd1}], memory[{d_addr[P-1:2], 2'd0}]};

   assign d_mmio = (d_addr == MMIO_PRINT) | (d_addr == MMIO_EXT_IRQ) |
                   (d_addr == MMIO_SOFT_IRQ);

   always_comb begin
      d_rdata = d_word;
      if (d_addr == MMIO_EXT_IRQ)       d_rdata = {31'b0, ext_irq};
      else if (d_addr == MMIO_SOFT_IRQ) d_rdata = {31'b0, soft_irq};
      else if (d_addr == MMIO_PRINT)    d_rdata = '0;
   end

   always_comb begin
      d_be = 4'b0000;
      case (d_size)
         HSIZE_BYTE: d_be[d_addr[1:0]] = 1'b1;
         HSIZE_HALF: d_be = d_addr[1] ? 4'b1100 : 4'b0011;
         HSIZE_WORD: d_be = 4'b1111;
         default:    d_be = 4'b1111;
      endcase
   end

   assign imem_hrdata = i_done ? i_word : '0;
   assign dmem_hrdata = (d_done & ~d_write) ? d_rdata : '0;
   assign imem_hresp  = 1'b0;
   assign dmem_hresp  = 1'b0;

   // Write data sits on its natural AHB byte lanes.
   always_ff @(posedge clk) begin
      if (d_done & d_write & ~d_mmio) begin
         for (int b = 0; b < 4; b++) begin
            if (d_be[b]) memory[{d_addr[P-1:2], 2'(b)}] <= dmem_hwdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ext_irq  <= 1'b0;
         soft_irq <= 1'b0;
      end else if (d_done & d_write) begin
         if (d_addr == MMIO_EXT_IRQ)  ext_irq  <= dmem_hwdata[0];
         if (d_addr == MMIO_SOFT_IRQ) soft_irq <= dmem_hwdata[0];
         if (d_addr == MMIO_PRINT)    $write("%c", dmem_hwdata[7:0]);
      end
   end

endmodule

// File: tb/tb_scr1_ahb_tb_mem.sv
// Randomized scoreboard bench for scr1_ahb_tb_mem against a byte-map model.
`timescale 1ns/1ps
module tb_scr1_ahb_tb_mem;

   localparam int          MSIZE   = 1 << 16;
   localparam int          BUDGET  = 100;
   localparam logic [31:0] A_PRINT = 32'hF000_0000;
   localparam logic [31:0] A_EXT   = 32'hF000_0100;
   localparam logic [31:0] A_SOFT  = 32'hF000_0200;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ext_irq, soft_irq;
   logic [31:0] imem_stall = 32'hFFFF_FFFF;
   logic [31:0] dmem_stall = 32'hFFFF_FFFF;
   logic [2:0]  imem_hsize = 3'd2;
   logic [1:0]  imem_htrans = 2'b00;
   logic [31:0] imem_haddr = '0;
   logic        imem_hready, imem_hresp;
   logic [31:0] imem_hrdata;
   logic [2:0]  dmem_hsize = 3'd2;
   logic [1:0]  dmem_htrans = 2'b00;
   logic [31:0] dmem_haddr = '0;
   logic        dmem_hwrite = 1'b0;
   logic [31:0] dmem_hwdata = '0;
   logic        dmem_hready, dmem_hresp;
   logic [31:0] dmem_hrdata;

   scr1_ahb_tb_mem dut (
      .clk                   (clk),
      .rst                   (rst),
      .ext_irq               (ext_irq),
      .soft_irq              (soft_irq),
      .imem_req_ack_stall_in (imem_stall),
      .dmem_req_ack_stall_in (dmem_stall),
      .imem_hsize            (imem_hsize),
      .imem_htrans           (imem_htrans),
      .imem_haddr            (imem_haddr),
      .imem_hready           (imem_hready),
      .imem_hrdata           (imem_hrdata),
      .imem_hresp            (imem_hresp),
      .dmem_hsize            (dmem_hsize),
      .dmem_htrans           (dmem_htrans),
      .dmem_haddr            (dmem_haddr),
      .dmem_hwrite           (dmem_hwrite),
      .dmem_hwdata           (dmem_hwdata),
      .dmem_hready           (dmem_hready),
      .dmem_hrdata           (dmem_hrdata),
      .dmem_hresp            (dmem_hresp)
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] i_exp_q[$];
   logic [31:0] d_exp_q[$];
   logic [7:0]  mem_m [int unsigned];
   bit          ext_m = 1'b0;
   bit          soft_m = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: a sparse byte map indexed by address modulo memory size.
   function automatic logic [31:0] m_read(input logic [31:0] a);
      logic [31:0] r;
      int unsigned base;
      r = '0;
      if (a == A_EXT)   return {31'b0, ext_m};
      if (a == A_SOFT)  return {31'b0, soft_m};
      if (a == A_PRINT) return 32'h0;
      base = (a & 32'(MSIZE - 1)) & 32'hFFFF_FFFC;
      for (int b = 0; b < 4; b++)
         if (mem_m.exists(base + b)) r[8*b +: 8] = mem_m[base + b];
      return r;
   endfunction

   function automatic void m_write(input logic [31:0] a, input logic [2:0] size,
                                   input logic [31:0] wd);
      int unsigned base;
      int lo, n;
      if (a == A_EXT)  begin ext_m  = wd[0]; return; end
      if (a == A_SOFT) begin soft_m = wd[0]; return; end
      if (a == A_PRINT) return;
      base = (a & 32'(MSIZE - 1)) & 32'hFFFF_FFFC;
      if (size == 3'd0)      begin lo = int'(a[1:0]);   n = 1; end
      else if (size == 3'd1) begin lo = a[1] ? 2 : 0;   n = 2; end
      else                   begin lo = 0;              n = 4; end
      for (int b = lo; b < lo + n; b++) mem_m[base + b] = wd[8*b +: 8];
   endfunction

   // Waits for hready at a falling edge, then steps past the next rising edge.
   task automatic wait_ready(input bit is_d, input string name);
      int n;
      n = 0;
      @(negedge clk);
      while (!(is_d ? dmem_hready : imem_hready)) begin
         n++;
         if (n > BUDGET) begin
            n_vec++;
            n_err++;
            $display("FAIL %s timeout: hready still 0 after %0d cycles, required 1", name, n);
            break;
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic d_issue(input bit w, input logic [31:0] a, input logic [2:0] s,
                          input logic [31:0] wd, input bit commit);
      dmem_htrans = {1'b1, 1'($urandom_range(0, 1))};
      dmem_haddr  = a;
      dmem_hsize  = s;
      dmem_hwrite = w;
      wait_ready(1'b1, "dmem_accept");
      dmem_htrans = 2'b00;
      dmem_hwdata = wd;
      if (commit) begin
         if (w) m_write(a, s, wd);
         else   d_exp_q.push_back(m_read(a));
      end
   endtask

   task automatic i_issue(input logic [31:0] a);
      logic [31:0] e;
      e = m_read(a);
      imem_htrans = {1'b1, 1'($urandom_range(0, 1))};
      imem_haddr  = a;
      imem_hsize  = 3'd2;
      wait_ready(1'b0, "imem_accept");
      imem_htrans = 2'b00;
      i_exp_q.push_back(e);
   endtask

   task automatic do_reset(input logic [31:0] ist, input logic [31:0] dst);
      rst         = 1'b1;
      imem_stall  = ist;
      dmem_stall  = dst;
      imem_htrans = 2'b00;
      dmem_htrans = 2'b00;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_imem_hready", 32'(imem_hready), 32'h1);
      chk("rst_dmem_hready", 32'(dmem_hready), 32'h1);
      chk("rst_imem_hrdata", imem_hrdata, 32'h0);
      chk("rst_dmem_hrdata", dmem_hrdata, 32'h0);
      chk("rst_hresp", {30'b0, imem_hresp, dmem_hresp}, 32'h0);
      chk("rst_irqs", {30'b0, ext_irq, soft_irq}, 32'h0);
      @(posedge clk);
      #1;
      rst    = 1'b0;
      ext_m  = 1'b0;
      soft_m = 1'b0;
   endtask

   // Monitors: track accepted transfers from the bus and score each completion.
   initial begin : d_mon
      bit pend = 1'b0;
      bit pend_w = 1'b0;
      forever begin
         @(negedge clk);
         if (pend && dmem_hready && !rst) begin
            chk("dmem_hresp", 32'(dmem_hresp), 32'h0);
            if (!pend_w) begin
               if (d_exp_q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL dmem_unexpected: got %h with no expected entry", dmem_hrdata);
               end else chk("dmem_hrdata", dmem_hrdata, d_exp_q.pop_front());
            end
         end
         if (rst) pend = 1'b0;
         else if (dmem_hready) begin
            pend   = dmem_htrans[1];
            pend_w = dmem_hwrite;
         end
      end
   end

   initial begin : i_mon
      bit pend = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst && !pend) chk("imem_idle_hrdata", imem_hrdata, 32'h0);
         if (pend && imem_hready && !rst) begin
            chk("imem_hresp", 32'(imem_hresp), 32'h0);
            if (i_exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL imem_unexpected: got %h with no expected entry", imem_hrdata);
            end else chk("imem_hrdata", imem_hrdata, i_exp_q.pop_front());
         end
         if (rst) pend = 1'b0;
         else if (imem_hready) pend = imem_htrans[1];
      end
   end

   initial begin : watchdog
      #800000;
      $display("FAIL watchdog: time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      logic [31:0] a;
      do_reset(32'hFFFF_FFFF, 32'h0000_0002);

      // One wait state on the first DMEM transfer, then read back.
      d_issue(1'b1, 32'h200, 3'd2, 32'h1234_5678, 1'b1);
      @(negedge clk); chk("t2_wait_hready", 32'(dmem_hready), 32'h0);
      @(negedge clk); chk("t2_done_hready", 32'(dmem_hready), 32'h1);
      @(posedge clk); #1;
      d_issue(1'b0, 32'h200, 3'd2, 32'h0, 1'b1);
      wait_ready(1'b1, "t2_drain");

      // Zero pattern must fall back to no wait states.
      do_reset(32'hFFFF_FFFF, 32'h0000_0000);
      d_issue(1'b1, 32'h100, 3'd2, 32'hDEAD_BEEF, 1'b1);
      @(negedge clk); chk("zero_stall_hready", 32'(dmem_hready), 32'h1);
      @(posedge clk); #1;
      i_issue(32'h100);
      @(negedge clk);
      chk("t1_imem_hready", 32'(imem_hready), 32'h1);
      chk("t1_imem_hrdata", imem_hrdata, 32'hDEAD_BEEF);
      @(posedge clk); #1;

      // Sub-word writes merged into a zeroed word.
      d_issue(1'b1, 32'h200, 3'd2, 32'h0, 1'b1);
      d_issue(1'b1, 32'h203, 3'd0, 32'hABAB_ABAB, 1'b1);
      d_issue(1'b1, 32'h200, 3'd1, 32'hCDEF_CDEF, 1'b1);
      d_issue(1'b0, 32'h200, 3'd2, 32'h0, 1'b1);
      wait_ready(1'b1, "t3_drain");

      // MMIO interrupts and console.
      d_issue(1'b1, A_EXT, 3'd2, 32'h1, 1'b1);
      wait_ready(1'b1, "t4_drain");
      @(negedge clk); chk("t4_ext_set", 32'(ext_irq), 32'h1);
      @(posedge clk); #1;
      d_issue(1'b1, A_SOFT, 3'd2, 32'h1, 1'b1);
      wait_ready(1'b1, "t4_drain");
      @(negedge clk); chk("t4_soft_set", 32'(soft_irq), 32'h1);
      @(posedge clk); #1;
      d_issue(1'b0, A_EXT, 3'd2, 32'h0, 1'b1);
      d_issue(1'b1, A_PRINT, 3'd2, 32'h0000_000A, 1'b1);
      d_issue(1'b0, A_PRINT, 3'd2, 32'h0, 1'b1);
      d_issue(1'b1, A_EXT, 3'd2, 32'h0, 1'b1);
      d_issue(1'b1, A_SOFT, 3'd2, 32'h0, 1'b1);
      d_issue(1'b0, A_SOFT, 3'd2, 32'h0, 1'b1);
      wait_ready(1'b1, "t4_drain");
      @(negedge clk); chk("t4_irqs_clear", {30'b0, ext_irq, soft_irq}, 32'h0);
      @(posedge clk); #1;

      // Same-cycle IMEM read and DMEM write to one word.
      d_issue(1'b1, 32'h300, 3'd2, 32'h1111_1111, 1'b1);
      d_issue(1'b1, 32'h400, 3'd2, 32'h0BAD_F00D, 1'b1);
      wait_ready(1'b1, "t5_drain");
      fork
         i_issue(32'h300);
         d_issue(1'b1, 32'h300, 3'd2, 32'h2222_2222, 1'b1);
      join
      @(negedge clk); chk("t5_imem_old", imem_hrdata, 32'h1111_1111);
      @(posedge clk); #1;
      i_issue(32'h300);
      wait_ready(1'b0, "t5_drain");

      // Randomized traffic on both ports with random stall patterns.
      do_reset($urandom | $urandom, $urandom | $urandom);
      for (int k = 0; k < 64; k++) d_issue(1'b1, 32'h1000 + 32'(4 * k), 3'd2, $urandom, 1'b1);
      for (int k = 0; k < 64; k++) d_issue(1'b1, 32'h2000 + 32'(4 * k), 3'd2, $urandom, 1'b1);
      wait_ready(1'b1, "rand_preload");
      fork
         begin
            logic [31:0] ia;
            for (int k = 0; k < 60; k++) begin
               if ($urandom_range(0, 3) == 0) begin
                  imem_htrans = 2'b01;
                  imem_haddr  = $urandom;
                  @(posedge clk); #1;
                  imem_htrans = 2'b00;
               end
               ia = ($urandom_range(0, 32'hEFFF) << 16) | 32'h1000 |
                    ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
               i_issue(ia);
            end
            wait_ready(1'b0, "rand_imem_drain");
         end
         begin
            for (int k = 0; k < 120; k++) begin
               a = ($urandom_range(0, 32'hEFFF) << 16) | 32'h2000 |
                   ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
               if ($urandom_range(0, 9) == 0) begin
                  dmem_htrans = 2'b01;
                  dmem_haddr  = a;
                  dmem_hwrite = 1'b1;
                  @(posedge clk); #1;
                  dmem_htrans = 2'b00;
               end else begin
                  d_issue(1'($urandom_range(0, 1)), a, 3'($urandom_range(0, 2)), $urandom, 1'b1);
               end
            end
            wait_ready(1'b1, "rand_dmem_drain");
         end
      join

      // Reset in the middle of a stalled write aborts it.
      do_reset(32'hFFFF_FFFF, 32'h0000_0008);
      d_issue(1'b1, A_EXT, 3'd2, 32'h1, 1'b1);
      wait_ready(1'b1, "t6_drain");
      d_issue(1'b1, 32'h400, 3'd2, 32'h5A5A_5A5A, 1'b0);
      @(negedge clk); chk("t6_stalled", 32'(dmem_hready), 32'h0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk); chk("t6_rst_hready", 32'(dmem_hready), 32'h1);
      @(posedge clk); #1;
      rst    = 1'b0;
      ext_m  = 1'b0;
      soft_m = 1'b0;
      @(negedge clk);
      chk("t6_irqs_cleared", {30'b0, ext_irq, soft_irq}, 32'h0);
      chk("t6_hready_after", 32'(dmem_hready), 32'h1);
      @(posedge clk); #1;
      d_issue(1'b0, 32'h400, 3'd2, 32'h0, 1'b1);
      wait_ready(1'b1, "t6_drain");
      repeat (2) @(posedge clk);

      chk("imem_queue_empty", 32'(i_exp_q.size()), 32'h0);
      chk("dmem_queue_empty", 32'(d_exp_q.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/scr1_ahb_tb_mem.md
Name: scr1_ahb_tb_mem

Overview:
- Behavioural dual-port AHB-Lite slave memory for the SCR1 AHB top-level simulation environment.
- Serves instruction fetches on a read-only IMEM port and loads/stores on a read/write DMEM port, both from one shared byte array.
- Provides simulation MMIO for console print, external IRQ and software IRQ.
- Wait states on each port are programmable through a rotating stall pattern.

Parameters:
- SCR1_MEM_POWER_SIZE, 16: log2 of memory size in bytes. The array holds 2**SCR1_MEM_POWER_SIZE bytes.
- SCR1_AHB_WIDTH, 32: AHB address and data width.

Ports:
clk  in  1  single clock; all logic samples on its rising edge
rst  in  1  synchronous, active-high reset
ext_irq  out  1  external interrupt request, set via MMIO
soft_irq  out  1  software interrupt request, set via MMIO
imem_req_ack_stall_in  in  32  IMEM stall pattern, sampled during reset
dmem_req_ack_stall_in  in  32  DMEM stall pattern, sampled during reset
imem_hsize  in  3  IMEM transfer size
imem_htrans  in  2  IMEM transfer type
imem_haddr  in  32  IMEM address
imem_hready  out  1  IMEM transfer done / ready
imem_hrdata  out  32  IMEM read data
imem_hresp  out  1  IMEM response; always OKAY (0)
dmem_hsize  in  3  DMEM transfer size
dmem_htrans  in  2  DMEM transfer type
dmem_haddr  in  32  DMEM address
dmem_hwrite  in  1  DMEM write (1) / read (0)
dmem_hwdata  in  32  DMEM write data, valid in data phase
dmem_hready  out  1  DMEM transfer done / ready
dmem_hrdata  out  32  DMEM read data
dmem_hresp  out  1  DMEM response; always OKAY (0)

Behaviour:
Reset:
- Single clock clk; reset rst is synchronous and active-high.
- While rst=1: hready=1, hrdata=0, hresp=0, ext_irq=0, soft_irq=0, pending data phases cleared.
- Each stall register loads its *_req_ack_stall_in; a zero pattern is replaced by 32'hFFFF_FFFF.
- Array contents are not reset; they are preloaded hierarchically (array name "memory", byte-wide, little-endian).

Address and data phases (identical per port):
- An address phase is accepted when htrans[1]=1 (NONSEQ/SEQ) and hready=1. The port latches haddr, hsize and hwrite.
- IDLE/BUSY transfers are ignored.
- The data phase starts the next cycle. During it, hready = stall_reg[0].
- stall_reg rotates right by 1 every data-phase cycle.
- The data phase ends on the cycle hready=1. A new address phase may be accepted in that same cycle (pipelined, back-to-back).
- Outside a data phase, hready=1.
- Pattern FFFF_FFFF gives zero wait states. Pattern 0000_0002 gives 1 wait state on the first transfer.

Reads:
- hrdata = word at {addr[P-1:2],2'b00}, driven while hready=1 in the data phase. The full word is returned regardless of hsize.
- Addresses wrap modulo the memory size, and hrdata is 0 outside a data phase.

Writes (DMEM):
- Committed at the completing data-phase cycle using dmem_hwdata. Byte lanes:
  - hsize=0: byte addr[1:0]
  - hsize=1: half at addr[1]
  - hsize≥2: all four bytes

Collisions:
- An IMEM read and a DMEM write to the same word completing in the same cycle: the read returns the old data.

MMIO (DMEM only; these addresses are not backed by the array):
- 0xF000_0000 PRINT: a write $write's the character hwdata[7:0].
- 0xF000_0100 EXT_IRQ: a write sets ext_irq<=hwdata[0].
- 0xF000_0200 SOFT_IRQ: a write sets soft_irq<=hwdata[0].
- Reads return {31'b0,reg} for the IRQ registers and 0 for PRINT.

Error handling and reset interaction:
- hresp is never 1. Unaligned accesses are not checked.
- Reset mid-transfer aborts the data phase; no write is committed.

Decomposition:
- Package scr1_ahb_tb_pkg holds:
  - HTRANS codes (IDLE/BUSY/NONSEQ/SEQ)
  - HSIZE codes (BYTE/HALF/WORD)
  - MMIO addresses PRINT/EXT_IRQ/SOFT_IRQ
  - default stall pattern FFFF_FFFF
- One sub-module, scr1_ahb_tb_port_ctrl, instantiated twice. It owns the stall register, data-phase flag, latched address/size/write, and hready generation.
- The shared array, write lanes and MMIO live in the top.

Test Plan:
1. Reset with stall=FFFF_FFFF; preload word 0x100=0xDEADBEEF; IMEM NONSEQ read 0x100 -> next cycle hready=1, hrdata=0xDEADBEEF, hresp=0.
2. DMEM stall=0000_0002; write word 0x200=0x12345678 -> data phase hready=0 for one cycle then 1. A subsequent DMEM read of 0x200 returns 0x12345678.
3. DMEM byte write 0xAB to 0x203 and half write 0xCDEF to 0x200 over 0x00000000 -> read of 0x200 returns 0xAB00CDEF.
4. DMEM write 1 to 0xF000_0100, then 1 to 0xF000_0200 -> ext_irq=1 and soft_irq=1 one cycle after the data phase. Writing 0 clears each; a read of 0xF000_0100 returns 1 while it is set.
5. Same cycle: IMEM read of 0x300 (old 0x11111111) and DMEM write of 0x22222222 to 0x300 -> IMEM returns 0x11111111; a later read returns 0x22222222.
6. Assert rst during a stalled DMEM write data phase -> write not committed, hready=1, ext_irq=soft_irq=0 next cycle.
